cam_match_encoder: RTL and testbench
====================================

Name: cam_match_encoder

Overview:
- Downstream stage of the CAM address decoder.
- During a search, the decoder's search_enable_o fans out to the CAM cells, and each cell returns a per-entry match line.
- This block captures the DEPTH-wide match vector and reports the lowest-index matching address.
- On request, it steps through every further match in ascending order, so that multi-hit searches can be fully resolved by the CAM controller.

Parameters:
- ADDR_WIDTH, 5, width of the entry address; must match the decoder.
- DEPTH, (1<<ADDR_WIDTH), number of CAM entries / match lines.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- reset_i  input  1  synchronous, active-high reset
- search_i  input  1  one-cycle strobe; capture match_lines_i this edge
- match_lines_i  input  DEPTH  per-entry match lines from the CAM cells; bit k = entry k hit
- next_i  input  1  consume the currently reported match and advance to the next
- valid_o  output  1  address_o/found_o/multi_o hold a valid result
- found_o  output  1  at least one unreported match remains
- address_o  output  ADDR_WIDTH  lowest-index pending match; 0 when found_o=0
- multi_o  output  1  two or more matches are pending, including the reported one
- done_o  output  1  one-cycle pulse when a search result has been fully consumed or reported as a miss

Behaviour:
- State: 1-bit FSM {IDLE, REPORT}; DEPTH-bit pending register.
- Reset (reset_i=1 at an edge): state=IDLE, pending=0, valid_o=0, found_o=0, address_o=0, multi_o=0, done_o=0. Reset overrides search_i and next_i in the same cycle.
- Outputs are combinational from registered state/pending only:
  - valid_o = (state==REPORT)
  - found_o = valid_o & |pending
  - address_o = index of the lowest set bit of pending, or 0 if none
  - multi_o = valid_o & (popcount(pending) >= 2)
- done_o is a registered one-cycle pulse.
- search_i=1, in any state: pending <= match_lines_i; state <= REPORT. Latency from search_i to valid_o is 1 cycle.
- search_i has priority over next_i in the same cycle. The old result is discarded and done_o is not pulsed for it.
- REPORT with pending!=0 and next_i=1, search_i=0:
  - pending <= pending & ~(1<<address_o).
  - If the new pending==0: state <= IDLE and done_o pulses in the next cycle.
  - Otherwise the state stays REPORT and the next-lowest match appears 1 cycle later.
- REPORT with pending==0 (miss), search_i=0:
  - valid_o=1 and found_o=0 are held for exactly one cycle.
  - Then state <= IDLE and done_o pulses in the following cycle.
  - next_i is ignored in this cycle.
- REPORT with next_i=0: outputs are held indefinitely; there is no timeout.
- IDLE with next_i=1: ignored; no state change.
- Priority encode: lowest index wins; the encoding is purely combinational over DEPTH bits.
- All-ones match vector: the block reports 0,1,...,DEPTH-1 on successive next_i.
  - multi_o drops on the last entry (address DEPTH-1).
  - done_o pulses after the final next_i.
- match_lines_i is sampled only on search_i cycles; changes at other times have no effect.

Optional Feature:
- Macro MATCH_COUNT_EN.
- Defined:
  - Adds output count_o, ADDR_WIDTH+1 bits, equal to popcount(pending) while valid_o=1 and 0 otherwise.
  - count_o is registered alongside pending: loaded with popcount(match_lines_i) on search_i, decremented by 1 on each accepted next_i.
- Undefined:
  - count_o does not exist and no popcount-register logic is built.
  - multi_o uses a combinational at-least-two-bits check.

Test Plan:
- Reset, then search_i with match_lines_i=32'h0000_0000 -> next cycle valid_o=1, found_o=0, address_o=0; following cycle valid_o=0, done_o=1 for one cycle.
- Search with 32'h0000_0100 -> valid_o=1, found_o=1, address_o=8, multi_o=0; next_i -> valid_o=0, done_o=1.
- Search with 32'h8000_0011 -> address_o sequence 0, 4, 31 on three next_i.
  - multi_o is 1, 1, 0.
  - With MATCH_COUNT_EN, count_o is 3, 2, 1.
  - done_o pulses after the third next_i.
- Search 32'h0000_0006, then assert search_i and next_i together with 32'h0000_0400 -> address_o=10 the next cycle; no done_o pulse.
- Search 32'hFFFF_FFFF with next_i held high -> addresses 0..31, one per cycle; done_o pulses after 32 cycles.
- Search 32'h0000_00F0, wait 3 cycles, then assert reset_i together with next_i -> all outputs 0 the next cycle; subsequent next_i is ignored.

Source files
------------

// File: rtl/cam_match_encoder.sv
// CAM match encoder: captures a match vector, reports matches lowest-first.
// Optional MATCH_COUNT_EN adds a registered pending-match count on count_o.
module cam_match_encoder #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = (1 << ADDR_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  search_i,
  input  logic [DEPTH-1:0]      match_lines_i,
  input  logic                  next_i,
  output logic                  valid_o,
  output logic                  found_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic                  multi_o,
  output logic                  done_o
`ifdef MATCH_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   count_o
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   pending_q, pending_d;
  logic               done_q, done_d;
  logic [DEPTH-1:0]   rest;
  logic               any_pend;
  logic               two_pend;
  logic [ADDR_WIDTH-1:0] enc;

  // Clearing the lowest set bit both advances and detects multi-hit.
  assign rest     = pending_q & (pending_q - DEPTH'(1));
  assign any_pend = |pending_q;
  assign two_pend = |rest;

  always_comb begin
    enc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (pending_q[i]) enc = i[ADDR_WIDTH-1:0];
    end
  end

`ifdef MATCH_COUNT_EN
  logic [ADDR_WIDTH:0] count_q, count_d;

  function automatic logic [ADDR_WIDTH:0] popcnt(
    input logic [DEPTH-1:0] v
  );
    logic [ADDR_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + (ADDR_WIDTH+1)'(v[i]);
    end
    return c;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
`ifdef MATCH_COUNT_EN
    count_d   = count_q;
`endif
    if (search_i) begin
      state_d   = REPORT;
      pending_d = match_lines_i;
`ifdef MATCH_COUNT_EN
      count_d   = popcnt(match_lines_i);
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        REPORT: begin
          if (!any_pend) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (next_i) begin
            pending_d = rest;
`ifdef MATCH_COUNT_EN
            count_d   = count_q - (ADDR_WIDTH+1)'(1);
`endif
            if (!two_pend) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
`ifdef MATCH_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
`ifdef MATCH_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  assign valid_o   = (state_q == REPORT);
  assign found_o   = valid_o & any_pend;
  assign address_o = enc;
  assign done_o    = done_q;

`ifdef MATCH_COUNT_EN
  assign multi_o = valid_o & (count_q >= (ADDR_WIDTH+1)'(2));
  assign count_o = valid_o ? count_q : '0;
`else
  assign multi_o = valid_o & two_pend;
`endif

endmodule

// File: tb/tb_cam_match_encoder.sv
// Directed scoreboard bench for cam_match_encoder.
// Expected outputs are queued with each stimulus step and checked after the edge.
module tb_cam_match_encoder;

  localparam int AW = 5;
  localparam int DP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          search_i = 1'b0;
  logic [DP-1:0] match_lines_i = '0;
  logic          next_i = 1'b0;
  logic          valid_o, found_o, multi_o, done_o;
  logic [AW-1:0] address_o;
  logic [AW:0]   cnt_obs;

  typedef struct packed {
    logic          v;
    logic          f;
    logic [AW-1:0] a;
    logic          m;
    logic          d;
    logic [AW:0]   c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cam_match_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .search_i      (search_i),
    .match_lines_i (match_lines_i),
    .next_i        (next_i),
    .valid_o       (valid_o),
    .found_o       (found_o),
    .address_o     (address_o),
    .multi_o       (multi_o),
    .done_o        (done_o)
`ifdef MATCH_COUNT_EN
    ,
    .count_o       (cnt_obs)
`endif
  );

`ifndef MATCH_COUNT_EN
  assign cnt_obs = '0;
`endif

  task automatic step(
    input string         tag,
    input logic          s,
    input logic [DP-1:0] ml,
    input logic          n,
    input logic          r,
    input exp_t          e
  );
    exp_t ex, ob;
`ifndef MATCH_COUNT_EN
    e.c = '0;
`endif
    exp_q.push_back(e);
    @(negedge clk);
    search_i      = s;
    match_lines_i = ml;
    next_i        = n;
    reset_i       = r;
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    ob = '{v: valid_o, f: found_o, a: address_o,
           m: multi_o, d: done_o, c: cnt_obs};
    checks++;
    assert (ob === ex) else begin
      failures++;
      $error("FAIL %s got v%0b f%0b a%0d m%0b d%0b c%0d want v%0b f%0b a%0d m%0b d%0b c%0d",
             tag, ob.v, ob.f, ob.a, ob.m, ob.d, ob.c,
             ex.v, ex.f, ex.a, ex.m, ex.d, ex.c);
    end
  endtask

  function automatic exp_t mk(
    input logic v, input logic f, input int a,
    input logic m, input logic d, input int c
  );
    mk = '{v: v, f: f, a: a[AW-1:0], m: m, d: d, c: c[AW:0]};
  endfunction

  exp_t zero;

  initial begin
    zero = mk(0, 0, 0, 0, 0, 0);
    step("reset", 0, '0, 0, 1, zero);
    step("reset_hold", 0, '0, 0, 1, zero);

    step("miss_rep", 1, 32'h0000_0000, 0, 0, mk(1, 0, 0, 0, 0, 0));
    step("miss_done", 0, '0, 0, 0, mk(0, 0, 0, 0, 1, 0));
    step("miss_idle", 0, '0, 0, 0, zero);

    step("one_rep", 1, 32'h0000_0100, 0, 0, mk(1, 1, 8, 0, 0, 1));
    step("one_done", 0, '0, 1, 0, mk(0, 0, 0, 0, 1, 0));
    step("one_idle", 0, '0, 0, 0, zero);

    step("tri_0", 1, 32'h8000_0011, 0, 0, mk(1, 1, 0, 1, 0, 3));
    step("tri_hold", 0, 32'h0000_0002, 0, 0, mk(1, 1, 0, 1, 0, 3));
    step("tri_4", 0, '0, 1, 0, mk(1, 1, 4, 1, 0, 2));
    step("tri_31", 0, '0, 1, 0, mk(1, 1, 31, 0, 0, 1));
    step("tri_done", 0, '0, 1, 0, mk(0, 0, 0, 0, 1, 0));
    step("tri_idle", 0, '0, 1, 0, zero);

    step("pri_a", 1, 32'h0000_0006, 0, 0, mk(1, 1, 1, 1, 0, 2));
    step("pri_b", 1, 32'h0000_0400, 1, 0, mk(1, 1, 10, 0, 0, 1));
    step("pri_done", 0, '0, 1, 0, mk(0, 0, 0, 0, 1, 0));
    step("pri_idle", 0, '0, 0, 0, zero);

    step("all_0", 1, 32'hFFFF_FFFF, 1, 0, mk(1, 1, 0, 1, 0, 32));
    for (int k = 1; k < DP; k++) begin
      step("all_k", 0, '0, 1, 0, mk(1, 1, k, k < DP - 1, 0, DP - k));
    end
    step("all_done", 0, '0, 1, 0, mk(0, 0, 0, 0, 1, 0));
    step("all_idle", 0, '0, 0, 0, zero);

    step("rst_a", 1, 32'h0000_00F0, 0, 0, mk(1, 1, 4, 1, 0, 4));
    for (int k = 0; k < 3; k++) begin
      step("rst_wait", 0, '0, 0, 0, mk(1, 1, 4, 1, 0, 4));
    end
    step("rst_mid", 0, '0, 1, 1, zero);
    step("rst_next", 0, '0, 1, 0, zero);
    step("rst_next2", 0, '0, 1, 0, zero);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
